// File: rtl/fb_cmd_pkg.sv
// Shared definitions for the framebuffer command controller.
// Latency: n/a (constants, types and pure byte-rotate helpers only).
// Backpressure: n/a.
// Contents: opcode constants, FSM state encoding, 8-bit rotate helpers.
package fb_cmd_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_CLR    = 3'd3;
  localparam logic [2:0] OP_XOR    = 3'd4;
  localparam logic [2:0] OP_ROTL   = 3'd5;
  localparam logic [2:0] OP_ROTR   = 3'd6;
  localparam logic [2:0] OP_COMMIT = 3'd7;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Rotating a doubled copy keeps a shift of 0 a clean no-op.
  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] w;
    w = {x, x} >> n;
    return w[7:0];
  endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Synchronises an asynchronous active-low vsync and flags the start of each pulse.
// Latency: frame_edge is high in the second cycle after vsync is first sampled low.
// Backpressure: none; frame_edge is a single-cycle strobe.
// Ports: clock, reset (sync, active-high), vga_vsync (async in), frame_edge (out).
module vsync_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic vga_vsync,
  output logic frame_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Flops rest at 1 (vsync idle level) so leaving reset never fakes an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= vga_vsync;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign frame_edge = r_s3 & ~r_s2;

endmodule

// File: rtl/fb_command_controller.sv
// Edits a shadow buffer via byte commands and swaps it to the displayed buffer at vsync.
// Latency: shadow updates on the accepting edge; swap registers two edges after vsync first samples low.
// Backpressure: cmd_ready drops while a COMMIT waits for the next frame boundary.
// Ports: clock/reset; cmd_valid/cmd_ready/cmd_op/cmd_data command channel;
//   scroll_en/scroll_dir auto-scroll control; vga_vsync frame timing input;
//   framebuffer, commit_pending, commit_done, frame_count status outputs.
module fb_command_controller
  import fb_cmd_pkg::*;
#(
  parameter logic [7:0] RESET_PATTERN = 8'h00,
  parameter int         SCROLL_FRAMES = 30,
  parameter int         FRAME_W       = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [7:0]         cmd_data,
  input  logic               scroll_en,
  input  logic               scroll_dir,
  input  logic               vga_vsync,
  output logic [7:0]         framebuffer,
  output logic               commit_pending,
  output logic               commit_done,
  output logic [FRAME_W-1:0] frame_count
);

  localparam logic [7:0]         SCROLL_LAST = 8'(SCROLL_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FC_ONE      = {{(FRAME_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_frame_edge;
  logic               w_accept;
  logic               w_swap;
  logic [7:0]         w_shadow_nxt;
  logic [7:0]         r_shadow;
  logic [7:0]         r_front;
  logic [7:0]         r_scroll_cnt;
  logic [FRAME_W-1:0] r_frame_count;
  logic               r_commit_done;

  vsync_edge_sync u_vsync_edge_sync (
    .clock      (clock),
    .reset      (reset),
    .vga_vsync  (vga_vsync),
    .frame_edge (w_frame_edge)
  );

  assign w_accept = cmd_valid & cmd_ready;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // A COMMIT accepted in IDLE ignores a coincident frame_edge: the swap can
  // only come from PENDING, so it naturally waits for the following boundary.
  always_comb begin
    w_state_nxt    = r_state;
    cmd_ready      = 1'b0;
    commit_pending = 1'b0;
    w_swap         = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && (cmd_op == OP_COMMIT)) w_state_nxt = PENDING;
      end
      PENDING: begin
        commit_pending = 1'b1;
        if (w_frame_edge) begin
          w_swap      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_shadow_nxt = r_shadow;
    case (cmd_op)
      OP_LOAD: w_shadow_nxt = cmd_data;
      OP_SET:  w_shadow_nxt = r_shadow | cmd_data;
      OP_CLR:  w_shadow_nxt = r_shadow & ~cmd_data;
      OP_XOR:  w_shadow_nxt = r_shadow ^ cmd_data;
      OP_ROTL: w_shadow_nxt = rotl8(r_shadow, cmd_data[2:0]);
      OP_ROTR: w_shadow_nxt = rotr8(r_shadow, cmd_data[2:0]);
      default: w_shadow_nxt = r_shadow;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)         r_shadow <= RESET_PATTERN;
    else if (w_accept) r_shadow <= w_shadow_nxt;
  end

  // Front buffer: a swap outranks a scroll step and restarts the scroll count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_front       <= RESET_PATTERN;
      r_scroll_cnt  <= 8'd0;
      r_frame_count <= '0;
      r_commit_done <= 1'b0;
    end else begin
      r_commit_done <= w_swap;
      if (w_frame_edge) r_frame_count <= r_frame_count + FC_ONE;
      if (w_swap) begin
        r_front      <= r_shadow;
        r_scroll_cnt <= 8'd0;
      end else if (!scroll_en) begin
        r_scroll_cnt <= 8'd0;
      end else if (w_frame_edge) begin
        if (r_scroll_cnt == SCROLL_LAST) begin
          r_front      <= scroll_dir ? rotr8(r_front, 3'd1) : rotl8(r_front, 3'd1);
          r_scroll_cnt <= 8'd0;
        end else begin
          r_scroll_cnt <= r_scroll_cnt + 8'd1;
        end
      end
    end
  end

  assign framebuffer = r_front;
  assign commit_done = r_commit_done;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_fb_command_controller.sv
// Directed bench for fb_command_controller with a commit scoreboard and front-buffer model.
// Latency: n/a.
// Backpressure: commands wait on cmd_ready with a bounded wait.
module tb_fb_command_controller;

  localparam int SF = 2;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        scroll_en;
  logic        scroll_dir;
  logic        vga_vsync;
  logic [7:0]  framebuffer;
  logic        commit_pending;
  logic        commit_done;
  logic [15:0] frame_count;

  int          n_cmp;
  int          n_mis;
  logic [7:0]  exp_q[$];
  logic [7:0]  sh_m;
  logic [7:0]  fb_m;
  int          sc;
  logic [15:0] fcnt;

  fb_command_controller #(
    .RESET_PATTERN (8'h00),
    .SCROLL_FRAMES (SF),
    .FRAME_W       (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .scroll_en      (scroll_en),
    .scroll_dir     (scroll_dir),
    .vga_vsync      (vga_vsync),
    .framebuffer    (framebuffer),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .frame_count    (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [7:0] m_rotr1(input logic [7:0] x);
    return {x[0], x[7:1]};
  endfunction

  // Apply an accepted command to the shadow model; COMMIT queues the value
  // the next swap must show.
  task automatic model_cmd(input logic [2:0] op, input logic [7:0] d);
    case (op)
      3'd1: sh_m = d;
      3'd2: sh_m = sh_m | d;
      3'd3: sh_m = sh_m & ~d;
      3'd4: sh_m = sh_m ^ d;
      3'd5: for (int k = 0; k < int'(d[2:0]); k++) sh_m = m_rotl1(sh_m);
      3'd6: for (int k = 0; k < int'(d[2:0]); k++) sh_m = m_rotr1(sh_m);
      3'd7: exp_q.push_back(sh_m);
      default: ;
    endcase
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] d);
    int w;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (w >= 50) chk("send_timeout", cmd_ready, 1);
    @(posedge clock);
    model_cmd(op, d);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // One vsync pulse; pops the scoreboard when commit_done fires and checks
  // the front buffer against the swap/scroll model.
  task automatic vframe(input bit expect_commit);
    int seen;
    logic [7:0] e;
    seen = 0;
    @(negedge clock);
    vga_vsync = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (commit_done) begin
        seen++;
        chk("commit_latency", i, 2);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("commit_fb", framebuffer, e);
          fb_m = e;
        end else begin
          chk("commit_unexpected", commit_done, 0);
        end
      end
      if (i == 2) vga_vsync = 1'b1;
    end
    chk("commit_count", seen, expect_commit ? 1 : 0);
    fcnt++;
    if (seen == 0) begin
      if (!scroll_en) sc = 0;
      else if (sc == SF - 1) begin
        fb_m = scroll_dir ? m_rotr1(fb_m) : m_rotl1(fb_m);
        sc   = 0;
      end else sc++;
    end else begin
      sc = 0;
    end
    chk("frame_count", frame_count, fcnt);
    chk("framebuffer", framebuffer, fb_m);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    sh_m = 8'h00; fb_m = 8'h00; sc = 0; fcnt = 16'd0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00;
    scroll_en = 1'b0; scroll_dir = 1'b0; vga_vsync = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_fb", framebuffer, 8'h00);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_pending", commit_pending, 0);
    chk("rst_done", commit_done, 0);
    chk("rst_fcount", frame_count, 0);

    // Commit waits indefinitely for a frame boundary.
    send(3'd1, 8'hA5);
    send(3'd7, 8'h00);
    repeat (100) @(negedge clock);
    chk("hold_fb", framebuffer, 8'h00);
    chk("hold_pending", commit_pending, 1);
    chk("hold_ready", cmd_ready, 0);
    vframe(1'b1);
    chk("t1_fb", framebuffer, 8'hA5);
    chk("t1_done_width", commit_done, 0);

    // Opcode chain.
    send(3'd1, 8'h0F);
    send(3'd2, 8'h80);
    send(3'd3, 8'h01);
    send(3'd4, 8'hFF);
    send(3'd5, 8'h03);
    send(3'd7, 8'h00);
    vframe(1'b1);
    chk("t2_fb", framebuffer, 8'h8B);
    send(3'd1, 8'h81);
    send(3'd6, 8'h01);
    send(3'd5, 8'h00);
    send(3'd0, 8'hFF);
    send(3'd7, 8'h00);
    vframe(1'b1);
    chk("t2_rotr_fb", framebuffer, 8'hC0);

    // Held command during PENDING is not accepted until after the swap.
    send(3'd1, 8'h22);
    send(3'd7, 8'h00);
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'h11;
    repeat (3) begin
      @(negedge clock);
      chk("held_ready", cmd_ready, 0);
    end
    vframe(1'b1);
    cmd_valid = 1'b0;
    sh_m = 8'h11;
    send(3'd7, 8'h00);
    vframe(1'b1);
    chk("t3_fb", framebuffer, 8'h11);

    // Auto-scroll left then right.
    send(3'd1, 8'h01);
    send(3'd7, 8'h00);
    vframe(1'b1);
    scroll_en = 1'b1; scroll_dir = 1'b0;
    vframe(1'b0); vframe(1'b0);
    chk("scroll_l2", framebuffer, 8'h02);
    vframe(1'b0); vframe(1'b0);
    chk("scroll_l4", framebuffer, 8'h04);
    vframe(1'b0); vframe(1'b0);
    chk("scroll_l6", framebuffer, 8'h08);
    scroll_dir = 1'b1;
    vframe(1'b0); vframe(1'b0);
    chk("scroll_r2", framebuffer, 8'h04);

    // Swap coinciding with a scroll step is shown unrotated.
    send(3'd1, 8'h5A);
    vframe(1'b0);
    send(3'd7, 8'h00);
    vframe(1'b1);
    chk("swap_over_scroll", framebuffer, 8'h5A);
    vframe(1'b0);
    vframe(1'b0);
    chk("scroll_after_swap", framebuffer, 8'h2D);
    scroll_en = 1'b0;

    // COMMIT accepted on the frame_edge cycle waits for the next edge.
    send(3'd1, 8'h3C);
    @(negedge clock);
    vga_vsync = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("coinc_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_data = 8'h00;
    @(negedge clock);
    cmd_valid = 1'b0;
    model_cmd(3'd7, 8'h00);
    fcnt++;
    chk("coinc_pending", commit_pending, 1);
    chk("coinc_no_done", commit_done, 0);
    chk("coinc_fb", framebuffer, fb_m);
    vga_vsync = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("coinc_no_done2", commit_done, 0);
    end
    chk("coinc_fcount", frame_count, fcnt);
    vframe(1'b1);
    chk("coinc_fb_after", framebuffer, 8'h3C);

    // Reset during PENDING aborts the commit.
    send(3'd1, 8'h77);
    send(3'd7, 8'h00);
    chk("pre_rst_pending", commit_pending, 1);
    @(negedge clock);
    reset = 1'b1;
    vga_vsync = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("rst_pulse_no_done", commit_done, 0);
    end
    vga_vsync = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    sh_m = 8'h00; fb_m = 8'h00; sc = 0; fcnt = 16'd0;
    exp_q.delete();
    @(negedge clock);
    chk("abort_fb", framebuffer, 8'h00);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_pending", commit_pending, 0);
    chk("abort_done", commit_done, 0);
    chk("abort_fcount", frame_count, 0);
    vframe(1'b0);
    chk("abort_fb_after_edge", framebuffer, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
